// File: rtl/multi_cycle_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencing control.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package multi_cycle_pkg;

    localparam int OP_WIDTH    = 6;
    localparam int ALUOP_WIDTH = 3;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b111
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = 6'b000000;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 6'b000001;
    localparam logic [OP_WIDTH-1:0] OP_ADDI = 6'b000010;
    localparam logic [OP_WIDTH-1:0] OP_OR   = 6'b010000;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 6'b010001;
    localparam logic [OP_WIDTH-1:0] OP_ORI  = 6'b010010;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 6'b010011;
    localparam logic [OP_WIDTH-1:0] OP_SW   = 6'b100110;
    localparam logic [OP_WIDTH-1:0] OP_LW   = 6'b100111;
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = 6'b110000;
    localparam logic [OP_WIDTH-1:0] OP_J    = 6'b111000;
    localparam logic [OP_WIDTH-1:0] OP_HALT = 6'b111111;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALUOP_WIDTH-1:0] ALU_RSUB = 3'b010;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 3'b011;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 3'b100;
    localparam logic [ALUOP_WIDTH-1:0] ALU_ANDN = 3'b101;
    localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = 3'b110;
    localparam logic [ALUOP_WIDTH-1:0] ALU_XNOR = 3'b111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU-side controls; held constant from EXE through WB.
    typedef struct packed {
        logic [ALUOP_WIDTH-1:0] op;
        logic                   src_b;
        logic                   ext_sel;
    } alu_t;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic [1:0] pc_src;
        alu_t       alu;
        logic       reg_dst;
        logic       reg_wre;
        logic       db_data_src;
        logic       m_rd;
        logic       m_wr;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_XOR,
            OP_SW, OP_LW, OP_BEQ, OP_J, OP_HALT: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_rtype(input logic [OP_WIDTH-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
               (op == OP_AND) || (op == OP_XOR);
    endfunction

    function automatic alu_t alu_sel(input logic [OP_WIDTH-1:0] op);
        alu_t a;
        a = '0;
        case (op)
            OP_SUB:              a.op = ALU_SUB;
            OP_OR:               a.op = ALU_OR;
            OP_AND:              a.op = ALU_AND;
            OP_XOR:              a.op = ALU_XOR;
            OP_ADDI, OP_LW, OP_SW: begin
                a.src_b   = 1'b1;
                a.ext_sel = 1'b1;
            end
            OP_ORI: begin
                a.op    = ALU_OR;
                a.src_b = 1'b1;
            end
            OP_BEQ: begin
                a.op      = ALU_SUB;
                a.ext_sel = 1'b1;
            end
            default:             a.op = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control <-> datapath bundle: opcode, ALU flag, memory ready handshakes and all enables.
// Latency: wires only.
// Backpressure: InsReady/DataReady stall the controller; master = controller, slave = datapath.
interface multi_cycle_control_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
);
    logic [OP_W-1:0]    Opcode;
    logic               zero;
    logic               InsReady;
    logic               DataReady;
    logic               PCWre;
    logic               IRWre;
    logic [1:0]         PCSrc;
    logic               ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic               ExtSel;
    logic               RegDst;
    logic               RegWre;
    logic               DBDataSrc;
    logic               mRD;
    logic               mWR;
    logic               Halted;
    logic               Illegal;
    logic [2:0]         State;

    modport master (
        input  Opcode, zero, InsReady, DataReady,
        output PCWre, IRWre, PCSrc, ALUSrcB, ALUOp, ExtSel, RegDst, RegWre,
               DBDataSrc, mRD, mWR, Halted, Illegal, State
    );

    modport slave (
        output Opcode, zero, InsReady, DataReady,
        input  PCWre, IRWre, PCSrc, ALUSrcB, ALUOp, ExtSel, RegDst, RegWre,
               DBDataSrc, mRD, mWR, Halted, Illegal, State
    );
endinterface

// File: rtl/multi_cycle_control_decode.sv
// Output decoder: (state, op_q, live opcode in ID, zero, ready flags) -> control vector.
// Latency: purely combinational.
// Backpressure: strobes stay asserted while the stalling ready flag is low.
// Ports: state/op_q from the sequencer, opcode is the IR field (only read in ID,
// before op_q has captured it), rst forces an all-zero vector.
module control_decode
    import multi_cycle_pkg::*;
(
    input  state_t              state,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] op_q,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                zero,
    input  logic                ins_ready,
    input  logic                data_ready,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            unique case (state)
                ST_IF: ctrl.ir_wre = ins_ready;
                ST_ID: begin
                    if (opcode == OP_J) begin
                        ctrl.pc_wre = 1'b1;
                        ctrl.pc_src = PC_JUMP;
                    end
                end
                ST_EXE: begin
                    ctrl.alu = alu_sel(op_q);
                    if (op_q == OP_BEQ) begin
                        ctrl.pc_wre = 1'b1;
                        ctrl.pc_src = zero ? PC_BRANCH : PC_SEQ;
                    end
                end
                ST_MEM: begin
                    // Address computation stays on the ALU for the whole access.
                    ctrl.alu  = alu_sel(op_q);
                    ctrl.m_wr = (op_q == OP_SW);
                    ctrl.m_rd = (op_q == OP_LW);
                    // A store retires here; a load retires in WB.
                    ctrl.pc_wre = (op_q == OP_SW) && data_ready;
                end
                ST_WB: begin
                    ctrl.alu         = alu_sel(op_q);
                    ctrl.reg_wre     = 1'b1;
                    ctrl.pc_wre      = 1'b1;
                    ctrl.reg_dst     = is_rtype(op_q);
                    ctrl.db_data_src = (op_q == OP_LW);
                    ctrl.m_rd        = (op_q == OP_LW);
                end
                ST_HALT: ctrl.halted = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU sequencer: walks IF/ID/EXE/MEM/WB and drives ALU, PC, IR, RF and memory enables.
// Latency: BEQ 3, J 2, SW 4, LW 5, R-type/immediate 4 cycles plus wait states.
// Backpressure: holds IF until InsReady, holds MEM (strobe asserted) until DataReady.
// Ports: CLK rising edge, Reset async active-high, bus = master side of multi_cycle_control_if.
module multi_cycle_control
    import multi_cycle_pkg::*;
#(
    parameter int OP_W    = OP_WIDTH,
    parameter int ALUOP_W = ALUOP_WIDTH
) (
    input  logic                  CLK,
    input  logic                  Reset,
    multi_cycle_control_if.master bus
);

    state_t          state;
    state_t          state_nxt;
    logic [OP_W-1:0] op_q;
    logic            illegal_q;
    ctrl_t           ctrl;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IF;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_ID) begin
                op_q <= bus.Opcode;
                if (!is_legal(bus.Opcode)) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IF: if (bus.InsReady) state_nxt = ST_ID;
            ST_ID: begin
                if (bus.Opcode == OP_J)
                    state_nxt = ST_IF;
                else if (bus.Opcode == OP_HALT || !is_legal(bus.Opcode))
                    state_nxt = ST_HALT;
                else
                    state_nxt = ST_EXE;
            end
            ST_EXE: begin
                if (op_q == OP_BEQ)
                    state_nxt = ST_IF;
                else if (op_q == OP_LW || op_q == OP_SW)
                    state_nxt = ST_MEM;
                else
                    state_nxt = ST_WB;
            end
            ST_MEM: if (bus.DataReady) state_nxt = (op_q == OP_SW) ? ST_IF : ST_WB;
            ST_WB:   state_nxt = ST_IF;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IF;
        endcase
    end

    control_decode u_decode (
        .state      (state),
        .rst        (Reset),
        .op_q       (op_q),
        .opcode     (bus.Opcode),
        .zero       (bus.zero),
        .ins_ready  (bus.InsReady),
        .data_ready (bus.DataReady),
        .ctrl       (ctrl)
    );

    assign bus.PCWre     = ctrl.pc_wre;
    assign bus.IRWre     = ctrl.ir_wre;
    assign bus.PCSrc     = ctrl.pc_src;
    assign bus.ALUSrcB   = ctrl.alu.src_b;
    assign bus.ALUOp     = ALUOP_W'(ctrl.alu.op);
    assign bus.ExtSel    = ctrl.alu.ext_sel;
    assign bus.RegDst    = ctrl.reg_dst;
    assign bus.RegWre    = ctrl.reg_wre;
    assign bus.DBDataSrc = ctrl.db_data_src;
    assign bus.mRD       = ctrl.m_rd;
    assign bus.mWR       = ctrl.m_wr;
    assign bus.Halted    = ctrl.halted;
    assign bus.Illegal   = illegal_q;
    assign bus.State     = state;

endmodule
